// File: rtl/raid_req_arbiter.sv
// Round-robin arbiter that shares one RAID controller among NREQ requesters,
// sequencing each transaction and returning data/status with a hang watchdog.
module raid_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_write,
    input  logic [32*NREQ-1:0]   req_addr,
    input  logic [32*NREQ-1:0]   req_din,
    output logic [NREQ-1:0]      req_ack,
    output logic [NREQ-1:0]      resp_valid,
    output logic [31:0]          resp_data,
    output logic                 resp_parity,
    output logic                 resp_err,
    output logic                 resp_timeout,
    input  logic [3:0]           cfg_raid_type,
    output logic                 raid_read_en,
    output logic                 raid_write_en,
    output logic [31:0]          raid_addr,
    output logic [31:0]          raid_din,
    output logic [3:0]           raid_type,
    input  logic                 raid_active,
    input  logic [31:0]          raid_dout,
    input  logic                 raid_parity,
    input  logic                 raid_err,
    output logic                 busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   ptr_reg;
    logic [PW-1:0]   gnt_reg;
    logic            wr_reg;
    logic [TW-1:0]   wd_reg;
    logic [31:0]     raid_addr_reg;
    logic [31:0]     raid_din_reg;
    logic [3:0]      raid_type_reg;
    logic [31:0]     resp_data_reg;
    logic            resp_parity_reg;
    logic            resp_err_reg;
    logic            resp_timeout_reg;

    logic [31:0]     addr_arr [NREQ];
    logic [31:0]     din_arr  [NREQ];
    logic [NREQ-1:0] upper_mask;
    logic [NREQ-1:0] req_hi;
    logic [PW-1:0]   hi_sel, lo_sel, gnt_sel;
    logic            grant_any;
    logic            wd_expired;
    logic            done_ok;
    logic            wd_abort;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign addr_arr[gi]   = req_addr[32*gi +: 32];
            assign din_arr[gi]    = req_din[32*gi +: 32];
            // Requesters at or above the pointer get first pick; the rest form the wrap-around pass.
            assign upper_mask[gi] = (PW'(gi) >= ptr_reg);
        end
    endgenerate

    assign req_hi    = req_valid & upper_mask;
    assign grant_any = |req_valid;

    always_comb begin
        hi_sel = '0;
        lo_sel = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req_hi[j])
                hi_sel = PW'(j);
            if (req_valid[j])
                lo_sel = PW'(j);
        end
        gnt_sel = (|req_hi) ? hi_sel : lo_sel;
    end

    assign wd_expired = (wd_reg == TW'(TIMEOUT - 1));
    assign done_ok    = (state_reg == S_WAIT_DONE) && !raid_active;
    assign wd_abort   = wd_expired &&
                        (((state_reg == S_WAIT_START) && !raid_active) ||
                         ((state_reg == S_WAIT_DONE)  &&  raid_active));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:       if (grant_any) state_next = S_ISSUE;
            S_ISSUE:      state_next = S_WAIT_START;
            S_WAIT_START: begin
                if (raid_active)
                    state_next = S_WAIT_DONE;
                else if (wd_abort)
                    state_next = S_RESP;
            end
            S_WAIT_DONE:  if (done_ok || wd_abort) state_next = S_RESP;
            S_RESP:       state_next = S_IDLE;
            default:      state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ack       = '0;
        resp_valid    = '0;
        raid_read_en  = 1'b0;
        raid_write_en = 1'b0;
        if (state_reg == S_ISSUE) begin
            req_ack[gnt_reg] = 1'b1;
            raid_write_en    = wr_reg;
            raid_read_en     = !wr_reg;
        end
        if (state_reg == S_RESP)
            resp_valid[gnt_reg] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg          <= '0;
            gnt_reg          <= '0;
            wr_reg           <= 1'b0;
            wd_reg           <= '0;
            raid_addr_reg    <= '0;
            raid_din_reg     <= '0;
            raid_type_reg    <= '0;
            resp_data_reg    <= '0;
            resp_parity_reg  <= 1'b0;
            resp_err_reg     <= 1'b0;
            resp_timeout_reg <= 1'b0;
        end else begin
            if (state_reg == S_IDLE) begin
                // Type tracks config only while idle so it never changes under a live transaction.
                raid_type_reg <= cfg_raid_type;
                if (grant_any) begin
                    gnt_reg       <= gnt_sel;
                    wr_reg        <= req_write[gnt_sel];
                    raid_addr_reg <= addr_arr[gnt_sel];
                    raid_din_reg  <= din_arr[gnt_sel];
                    ptr_reg       <= (gnt_sel == PW'(NREQ - 1)) ? '0 : gnt_sel + 1'b1;
                end
            end

            if ((state_reg == S_ISSUE) || ((state_reg == S_WAIT_START) && raid_active))
                wd_reg <= '0;
            else if ((state_reg == S_WAIT_START) || (state_reg == S_WAIT_DONE))
                wd_reg <= wd_reg + 1'b1;

            if (done_ok) begin
                resp_data_reg    <= wr_reg ? 32'h0 : raid_dout;
                resp_parity_reg  <= raid_parity;
                resp_err_reg     <= raid_err;
                resp_timeout_reg <= 1'b0;
            end else if (wd_abort) begin
                resp_data_reg    <= 32'h0;
                resp_parity_reg  <= 1'b0;
                resp_err_reg     <= 1'b0;
                resp_timeout_reg <= 1'b1;
            end
        end
    end

    assign raid_addr    = raid_addr_reg;
    assign raid_din     = raid_din_reg;
    assign raid_type    = raid_type_reg;
    assign resp_data    = resp_data_reg;
    assign resp_parity  = resp_parity_reg;
    assign resp_err     = resp_err_reg;
    assign resp_timeout = resp_timeout_reg;
    assign busy         = (state_reg != S_IDLE);

endmodule
